// File: rtl/tft_pkg.sv
// tft_pkg: shared FSM encoding, DC flag values and default timing for the TFT SPI path.
package tft_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} tft_state_e;
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;
    localparam int DEF_CLK_DIV        = 2;
    localparam int DEF_CS_IDLE_CYCLES = 16;
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/tft_spi_clkgen.sv
// tft_spi_clkgen: one-cycle phase tick every CLK_DIV enabled cycles; held cleared while disabled.
module tft_spi_clkgen
    import tft_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);
    localparam int W = cnt_width(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] r_cnt;
    assign o_tick = i_en && (r_cnt == LAST);
    always_ff @(posedge clk) begin
        if (rst || !i_en || o_tick) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/tft_spi_tx.sv
// tft_spi_tx: byte-wide SPI mode-0 master for the TFT panel; keeps CS low across
// back-to-back bytes and releases it after CS_IDLE_CYCLES of inactivity.
module tft_spi_tx
    import tft_pkg::*;
#(
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int CS_IDLE_CYCLES = DEF_CS_IDLE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tft_transmit,
    input  logic [7:0] tft_data,
    input  logic       tft_dc,
    output logic       tft_busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       spi_dc,
    output logic       done
);
    localparam int IW = cnt_width(CS_IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(CS_IDLE_CYCLES - 1);

    tft_state_e r_state, w_state;
    logic [6:0] r_sreg, w_sreg;
    logic [2:0] r_bit, w_bit;
    logic [IW-1:0] r_idle, w_idle;
    logic r_sck, r_mosi, r_cs_n, r_dc, r_busy, r_done;
    logic w_sck, w_mosi, w_cs_n, w_dc, w_busy, w_done;
    logic w_accept, w_tick, w_clk_en;

    assign w_clk_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
    assign w_accept = tft_transmit && ((r_state == ST_IDLE) || (r_state == ST_HOLD));

    tft_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_clk_en),
        .o_tick(w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_bit   <= '0;
            r_idle  <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_dc    <= DC_CMD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sreg  <= w_sreg;
            r_bit   <= w_bit;
            r_idle  <= w_idle;
            r_sck   <= w_sck;
            r_mosi  <= w_mosi;
            r_cs_n  <= w_cs_n;
            r_dc    <= w_dc;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_sreg  = r_sreg;
        w_bit   = r_bit;
        w_idle  = r_idle;
        w_sck   = r_sck;
        w_mosi  = r_mosi;
        w_cs_n  = r_cs_n;
        w_dc    = r_dc;
        w_busy  = r_busy;
        w_done  = 1'b0;
        if (w_accept) begin
            // bit 7 goes straight to MOSI, so only the remaining 7 bits are stored
            w_sreg  = tft_data[6:0];
            w_mosi  = tft_data[7];
            w_dc    = tft_dc;
            w_busy  = 1'b1;
            w_cs_n  = 1'b0;
            w_bit   = '0;
            w_idle  = '0;
            w_state = (r_state == ST_IDLE) ? ST_SETUP : ST_SHIFT;
        end else begin
            case (r_state)
                ST_SETUP: w_state = w_tick ? ST_SHIFT : ST_SETUP;
                ST_SHIFT: begin
                    if (w_tick) begin
                        w_sck = !r_sck;
                        if (r_sck) begin
                            w_sreg = {r_sreg[5:0], 1'b0};
                            w_mosi = r_sreg[6];
                            w_bit  = r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                w_busy  = 1'b0;
                                w_done  = 1'b1;
                                w_cs_n  = (CS_IDLE_CYCLES == 0);
                                w_state = (CS_IDLE_CYCLES == 0) ? ST_IDLE : ST_HOLD;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_idle == IDLE_LAST) begin
                        w_state = ST_IDLE;
                        w_cs_n  = 1'b1;
                        w_idle  = '0;
                    end else begin
                        w_idle = r_idle + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tft_busy = r_busy;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;
    assign spi_dc   = r_dc;
    assign done     = r_done;
endmodule

// File: tb/tb_tft_spi_tx.sv
// tb_tft_spi_tx: randomized checks of tft_spi_tx against a bus-level model
// (bytes decoded from SCK rises, busy length from the CS state at request).
module tb_tft_spi_tx;
    import tft_pkg::*;

    localparam int DIV_A  = 2;
    localparam int IDLE_A = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_a = 1'b0, dc_a = 1'b0, tx_b = 1'b0, dc_b = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic busy_a, sck_a, mosi_a, cs_a, sdc_a, done_a;
    logic busy_b, sck_b, mosi_b, cs_b, sdc_b, done_b;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    tft_spi_tx #(.CLK_DIV(DIV_A), .CS_IDLE_CYCLES(IDLE_A)) u_a (
        .clk(clk), .rst(rst), .tft_transmit(tx_a), .tft_data(data_a), .tft_dc(dc_a),
        .tft_busy(busy_a), .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_cs_n(cs_a),
        .spi_dc(sdc_a), .done(done_a)
    );

    tft_spi_tx #(.CLK_DIV(1), .CS_IDLE_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .tft_transmit(tx_b), .tft_data(data_b), .tft_dc(dc_b),
        .tft_busy(busy_b), .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_cs_n(cs_b),
        .spi_dc(sdc_b), .done(done_b)
    );

    // bus monitor for instance A: what a mode-0 panel would receive
    logic [8:0] got_q[$];
    logic [7:0] mon_byte = '0;
    int mon_bits = 0;
    int cs_rises = 0;
    logic prev_sck = 1'b0, prev_cs = 1'b1;

    always @(negedge clk) begin
        if (rst || cs_a !== 1'b0) begin
            mon_bits = 0;
        end else if (prev_sck == 1'b0 && sck_a == 1'b1) begin
            mon_byte = {mon_byte[6:0], mosi_a};
            mon_bits++;
            if (mon_bits == 8) begin
                got_q.push_back({sdc_a, mon_byte});
                mon_bits = 0;
            end
        end
        if (prev_cs == 1'b0 && cs_a == 1'b1) cs_rises++;
        prev_sck = sck_a;
        prev_cs  = cs_a;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic xfer_a(input logic [7:0] d, input logic c, output int nb,
                          output logic cs1, output logic dc1, output logic dn);
        tx_a = 1'b1; data_a = d; dc_a = c;
        @(posedge clk);
        #1 tx_a = 1'b0; data_a = 8'($urandom); dc_a = 1'($urandom);
        @(negedge clk);
        cs1 = cs_a; dc1 = sdc_a; nb = 0;
        while (busy_a === 1'b1 && nb < 400) begin
            nb++;
            @(negedge clk);
        end
        dn = done_a;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while ((cs_a !== 1'b1 || busy_a !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vec++; err++;
            $display("FAIL wait_idle: cs_n=%b busy=%b want cs_n=1 busy=0", cs_a, busy_a);
        end
        @(negedge clk);
    endtask

    function automatic logic [8:0] pop_got();
        logic [8:0] g = 9'bx;
        if (got_q.size() > 0) g = got_q.pop_front();
        return g;
    endfunction

    task automatic test_reset();
        logic [5:0] oa;
        logic [5:0] ob;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        oa = {sck_a, cs_a, mosi_a, sdc_a, busy_a, done_a};
        ob = {sck_b, cs_b, mosi_b, sdc_b, busy_b, done_b};
        vec++; if (oa !== 6'b010000) begin err++; $display("FAIL reset_a: got %b want 010000", oa); end
        vec++; if (ob !== 6'b010000) begin err++; $display("FAIL reset_b: got %b want 010000", ob); end
        rst = 1'b0;
        @(negedge clk);
        got_q.delete();
    endtask

    task automatic test_single();
        int nb; logic cs1, dc1, dn; logic [8:0] g;
        xfer_a(8'hA5, DC_DATA, nb, cs1, dc1, dn);
        g = pop_got();
        vec++; if (nb != 17 * DIV_A) begin err++; $display("FAIL single_busy: got %0d want %0d", nb, 17 * DIV_A); end
        vec++; if (cs1 !== 1'b0) begin err++; $display("FAIL single_cs_fall: got %b want 0", cs1); end
        vec++; if (dc1 !== 1'b1) begin err++; $display("FAIL single_dc: got %b want 1", dc1); end
        vec++; if (dn !== 1'b1) begin err++; $display("FAIL single_done: got %b want 1", dn); end
        vec++; if (g !== {1'b1, 8'hA5}) begin err++; $display("FAIL single_byte: got %h want 1a5", g); end
        @(negedge clk);
        vec++; if (done_a !== 1'b0) begin err++; $display("FAIL single_done_once: got %b want 0", done_a); end
        wait_idle_a();
    endtask

    task automatic test_idle_timeout();
        int nb, n, r; logic cs1, dc1, dn; logic [8:0] g;
        wait_idle_a();
        xfer_a(8'($urandom), 1'($urandom), nb, cs1, dc1, dn);
        n = 0;
        while (cs_a !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vec++; if (n != IDLE_A) begin err++; $display("FAIL idle_release: got %0d cycles want %0d", n, IDLE_A); end
        void'(pop_got());
        wait_idle_a();
        xfer_a(8'h5A, DC_CMD, nb, cs1, dc1, dn);
        repeat (IDLE_A - 1) @(negedge clk);
        #1 r = cs_rises;
        xfer_a(8'hC3, DC_DATA, nb, cs1, dc1, dn);
        #1;
        vec++; if (nb != 16 * DIV_A) begin err++; $display("FAIL expiry_accept_busy: got %0d want %0d", nb, 16 * DIV_A); end
        vec++; if (cs_rises != r) begin err++; $display("FAIL expiry_accept_cs: got %0d rises want %0d", cs_rises - r, 0); end
        void'(pop_got());
        g = pop_got();
        vec++; if (g !== {1'b1, 8'hC3}) begin err++; $display("FAIL expiry_accept_byte: got %h want 1c3", g); end
        wait_idle_a();
    endtask

    task automatic test_back_to_back();
        int nb, r; logic cs1, dc1, dn; logic [8:0] g;
        wait_idle_a();
        #1 r = cs_rises;
        xfer_a(8'h2C, DC_CMD, nb, cs1, dc1, dn);
        vec++; if (sdc_a !== 1'b0) begin err++; $display("FAIL b2b_dc_first: got %b want 0", sdc_a); end
        xfer_a(8'hFF, DC_DATA, nb, cs1, dc1, dn);
        #1;
        vec++; if (nb != 16 * DIV_A) begin err++; $display("FAIL b2b_busy: got %0d want %0d", nb, 16 * DIV_A); end
        vec++; if (dc1 !== 1'b1) begin err++; $display("FAIL b2b_dc_switch: got %b want 1", dc1); end
        vec++; if (cs_rises != r) begin err++; $display("FAIL b2b_cs_low: got %0d rises want 0", cs_rises - r); end
        g = pop_got();
        vec++; if (g !== {1'b0, 8'h2C}) begin err++; $display("FAIL b2b_byte0: got %h want 02c", g); end
        g = pop_got();
        vec++; if (g !== {1'b1, 8'hFF}) begin err++; $display("FAIL b2b_byte1: got %h want 1ff", g); end
        wait_idle_a();
    endtask

    task automatic test_mid_drop();
        int n; logic c; logic [8:0] g;
        wait_idle_a();
        c = 1'($urandom);
        tx_a = 1'b1; data_a = 8'h3C; dc_a = c;
        @(posedge clk);
        #1 tx_a = 1'b0;
        @(negedge clk);
        n = 0;
        while (busy_a === 1'b1 && n < 400) begin
            n++;
            tx_a = (n == 10); data_a = 8'h00; dc_a = ~c;
            @(negedge clk);
        end
        tx_a = 1'b0;
        wait_idle_a();
        g = pop_got();
        vec++; if (n != 17 * DIV_A) begin err++; $display("FAIL drop_busy: got %0d want %0d", n, 17 * DIV_A); end
        vec++; if (g !== {c, 8'h3C}) begin err++; $display("FAIL drop_byte: got %h want %h", g, {c, 8'h3C}); end
        vec++; if (got_q.size() != 0) begin err++; $display("FAIL drop_extra: got %0d extra bytes want 0", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        int nb; logic cs1, dc1, dn; logic c; logic [8:0] g; logic [2:0] o;
        wait_idle_a();
        tx_a = 1'b1; data_a = 8'hE7; dc_a = 1'b1;
        @(posedge clk);
        #1 tx_a = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        o = {cs_a, sck_a, busy_a};
        vec++; if (o !== 3'b100) begin err++; $display("FAIL rst_mid: got cs/sck/busy=%b want 100", o); end
        rst = 1'b0;
        @(negedge clk);
        vec++; if (got_q.size() != 0) begin err++; $display("FAIL rst_mid_partial: got %0d bytes want 0", got_q.size()); end
        c = 1'($urandom);
        xfer_a(8'h81, c, nb, cs1, dc1, dn);
        g = pop_got();
        vec++; if (nb != 17 * DIV_A) begin err++; $display("FAIL rst_after_busy: got %0d want %0d", nb, 17 * DIV_A); end
        vec++; if (g !== {c, 8'h81}) begin err++; $display("FAIL rst_after_byte: got %h want %h", g, {c, 8'h81}); end
        wait_idle_a();
    endtask

    task automatic test_random();
        int nb, g, want, rises_exp; logic cs1, dc1, dn; logic [7:0] d; logic c, from_idle; logic [8:0] got;
        wait_idle_a();
        #1 rises_exp = cs_rises;
        from_idle = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom); c = 1'($urandom);
            xfer_a(d, c, nb, cs1, dc1, dn);
            want = DIV_A * (16 + (from_idle ? 1 : 0));
            got = pop_got();
            vec++; if (nb != want) begin err++; $display("FAIL rand_busy[%0d]: got %0d want %0d", i, nb, want); end
            vec++; if (got !== {c, d} || dn !== 1'b1) begin err++; $display("FAIL rand_byte[%0d]: got %h done=%b want %h done=1", i, got, dn, {c, d}); end
            g = $urandom_range(0, 24);
            repeat (g) @(negedge clk);
            from_idle = (g >= IDLE_A);
            if (from_idle) rises_exp++;
        end
        #1;
        vec++; if (cs_rises != rises_exp) begin err++; $display("FAIL rand_cs_rises: got %0d want %0d", cs_rises, rises_exp); end
        wait_idle_a();
    endtask

    task automatic test_fast();
        int n, tog; logic [7:0] d, cap; logic c, ps, cs1;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 8'h01 : 8'($urandom);
            c = 1'($urandom);
            tx_b = 1'b1; data_b = d; dc_b = c;
            @(posedge clk);
            #1 tx_b = 1'b0;
            @(negedge clk);
            cs1 = cs_b; n = 0; tog = 0; ps = 1'b0; cap = '0;
            while (busy_b === 1'b1 && n < 100) begin
                n++;
                if (ps == 1'b0 && sck_b == 1'b1) cap = {cap[6:0], mosi_b};
                if (n > 1 && sck_b !== ps) tog++;
                ps = sck_b;
                @(negedge clk);
            end
            vec++; if (n != 17) begin err++; $display("FAIL fast_busy[%0d]: got %0d want 17", i, n); end
            vec++; if (tog != 15 || sck_b !== 1'b0) begin err++; $display("FAIL fast_sck[%0d]: got %0d toggles sck=%b want 15 sck=0", i, tog, sck_b); end
            vec++; if (cap !== d || sdc_b !== c) begin err++; $display("FAIL fast_byte[%0d]: got %h dc=%b want %h dc=%b", i, cap, sdc_b, d, c); end
            vec++; if (cs1 !== 1'b0 || cs_b !== 1'b1 || done_b !== 1'b1) begin err++; $display("FAIL fast_cs[%0d]: got cs_start=%b cs_end=%b done=%b want 0 1 1", i, cs1, cs_b, done_b); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_idle_timeout();
        test_back_to_back();
        test_mid_drop();
        test_reset_mid();
        test_random();
        test_fast();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/tft_spi_tx.md
Name: tft_spi_tx

Overview:
Byte-level SPI master that sits directly downstream of the TFT byte producers (init sequencer, scene_exhibitor). It consumes the tft_data / tft_dc / tft_transmit / tft_busy handshake and serialises each byte onto the panel's 4-wire SPI bus (SCK, MOSI, CS_n, DC), using SPI mode 0, MSB first. Chip-select is held low across back-to-back bytes and released only after a programmable idle time.

Parameters:
CLK_DIV, 2, SCK half-period in clk cycles; legal range 1..255.
CS_IDLE_CYCLES, 16, clk cycles of inactivity with CS low before CS is released; 0 = release after every byte.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tft_transmit  input  1  one-cycle byte request from the producer
tft_data  input  8  byte to send; sampled at accept
tft_dc  input  1  data/command flag (1 = data); sampled at accept
tft_busy  output  1  high while a byte is in flight; producers do not request while high
spi_sck  output  1  SPI clock; idles low
spi_mosi  output  1  serial data, MSB first
spi_cs_n  output  1  active-low chip select
spi_dc  output  1  registered DC line to the panel
done  output  1  one-cycle pulse on the cycle tft_busy falls

Behaviour:
- Reset values: spi_sck=0, spi_cs_n=1, spi_mosi=0, spi_dc=0, tft_busy=0, done=0. The state machine goes to IDLE and all counters clear.
- Reset takes priority in any state. A byte in flight when reset asserts is abandoned, and CS rises on the next edge.
- All outputs are registered.
- States:
  - IDLE: CS high.
  - SETUP: CS asserted, waiting for the first SCK.
  - SHIFT: 8 bits shifting.
  - HOLD: CS low, idle counting.
- Accept: tft_transmit=1 sampled at a clk edge while the state is IDLE or HOLD. On that edge:
  - latch tft_data into the shift register and tft_dc into spi_dc;
  - drive spi_mosi with bit 7;
  - set tft_busy=1, so it is high in the very next cycle. Producers rely on this to avoid double-issue.
- tft_transmit while tft_busy=1 is ignored. The byte is dropped and no state changes.
- From IDLE:
  - accept drives spi_cs_n=0 and enters SETUP;
  - SETUP lasts CLK_DIV cycles and then enters SHIFT.
- From HOLD: accept enters SHIFT directly with no setup; CS stays low.
- SHIFT:
  - each bit is SCK low for CLK_DIV cycles, then SCK high for CLK_DIV cycles;
  - the panel samples on the rising edge;
  - spi_mosi updates to the next bit on the edge where SCK returns low.
- After the 8th high phase:
  - SCK returns low;
  - tft_busy=0 and done=1 for one cycle;
  - the state machine enters HOLD (or IDLE with CS high when CS_IDLE_CYCLES=0).
- Busy duration, measured from the first busy cycle:
  - 16*CLK_DIV cycles when CS was already low;
  - 17*CLK_DIV cycles when started from IDLE.
- HOLD:
  - the idle counter increments each cycle without an accept;
  - on reaching CS_IDLE_CYCLES, spi_cs_n=1 and the state goes to IDLE;
  - an accept in the same cycle as expiry wins: CS stays low and the counter clears.
- spi_dc changes only at accept, including while CS is low between bytes.
- Width rules: the divider counter is $clog2(CLK_DIV+1) bits, the bit counter is 3 bits, and the idle counter is $clog2(CS_IDLE_CYCLES+1) bits (min 1).

Decomposition:
- Shared package tft_pkg:
  - state encoding typedef (IDLE/SETUP/SHIFT/HOLD);
  - DC_CMD=0 and DC_DATA=1 constants;
  - default CLK_DIV.
- One natural sub-module, tft_spi_clkgen: a divider emitting a one-cycle phase tick every CLK_DIV cycles when enabled, and cleared when disabled.

Test Plan:
- CLK_DIV=2, IDLE, send 0xA5 DC=1:
  - spi_cs_n falls the cycle after accept;
  - MOSI at 8 SCK rises reads 1,0,1,0,0,1,0,1;
  - spi_dc=1;
  - tft_busy high for exactly 34 cycles, then done pulses once.
- Back-to-back: 0x2C DC=0, then 0xFF DC=1 requested on the first cycle tft_busy=0:
  - CS stays low throughout;
  - the second byte is busy for 32 cycles;
  - spi_dc switches 0→1 at the second accept.
- Idle timeout (CS_IDLE_CYCLES=16): after a single byte, spi_cs_n rises exactly 16 cycles after tft_busy falls. A request at cycle 16 keeps CS low.
- tft_transmit pulsed at mid-byte (0x3C in flight, pulse 0x00): the serialised output remains 0x3C and no extra byte is sent.
- rst asserted during bit 4:
  - next cycle spi_cs_n=1, spi_sck=0, tft_busy=0;
  - a following 0x81 transmits cleanly.
- CLK_DIV=1 and CS_IDLE_CYCLES=0 with byte 0x01:
  - SCK toggles every cycle;
  - busy lasts 17 cycles;
  - CS rises on the cycle busy falls.
